inv_sub_byte_iter: RTL and testbench
====================================

INV_SUB_BYTE_ITER -- requirements
Module: inv_sub_byte_iter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed (128-bit AES state as four 32-bit column words).
REQ-002 The block SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  the source presents a state on S0_in..S3_in.
REQ-006 in_ready  output  1  the block accepts a state this cycle.
REQ-007 S0_in, S1_in, S2_in, S3_in  input  32 each  state columns 0..3; bits [31:24] hold row 0.
REQ-008 out_valid  output  1  D0_out..D3_out hold an InvSubBytes result.
REQ-009 out_ready  input  1  the sink takes the result this cycle.
REQ-010 D0_out, D1_out, D2_out, D3_out  output  32 each  result columns 0..3, in the same byte order as the inputs.

Function
REQ-011 Each output byte SHALL equal the FIPS-197 inverse S-box value of the corresponding input byte.
REQ-012 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-013 In IDLE, in_valid && in_ready SHALL register all four input words, clear the word counter and move to BUSY.
REQ-014 In BUSY, each cycle SHALL substitute word[cnt] and write it into the result register, then increment the 2-bit cnt.
REQ-015 When cnt==3 in BUSY, the FSM SHALL move to DONE on that edge; cnt wraps to 0.
REQ-016 Latency: out_valid SHALL rise 4 clock edges after the accepting edge.
REQ-017 In DONE, out_valid SHALL be 1, and D*_out SHALL stay stable while out_ready==0.
REQ-018 in_ready SHALL equal (state==IDLE) || (state==DONE && out_ready); the combinational out_ready->in_ready path is permitted.
REQ-019 DONE with out_ready=1 and in_valid=1 SHALL accept the new state and go directly to BUSY, giving back-to-back throughput of one state per 5 cycles.
REQ-020 DONE with out_ready=1 and in_valid=0 SHALL return to IDLE.
REQ-021 in_valid asserted during BUSY SHALL be ignored, because in_ready is 0.
REQ-022 Input words SHALL be sampled only on the accepting edge; later input changes SHALL not affect the result.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, cnt=0, out_valid=0, D0_out..D3_out=0 and all internal registers to 0.
REQ-024 Reset asserted in BUSY or DONE SHALL discard the operation; no partial result SHALL appear after reset.
REQ-025 After reset release, in_ready SHALL be 1 on the first cycle.

Configuration
REQ-026 The macro INV_SUB_BYTE_FAST_EN SHALL select the BUSY-stage implementation.
REQ-027 With INV_SUB_BYTE_FAST_EN defined, four inverse-word instances SHALL substitute all words in a single BUSY cycle, giving a latency of 1 edge.
REQ-028 With INV_SUB_BYTE_FAST_EN not defined, one shared instance SHALL be used, giving the 4-cycle behaviour in REQ-014 to REQ-016.
REQ-029 The handshake, reset and DONE behaviour SHALL be identical in both builds.

Structure
REQ-030 The shared package aes_pkg SHALL hold the 256-entry inverse S-box constant, the FSM state encoding and the word/byte width constants.
REQ-031 The block SHALL use one sub-module, InvSubWord, which maps 32 bits to 32 bits through four inverse S-box lookups and contains no state.

Verification
REQ-032 Accept S0..S3 = 63636363 each -> after 4 edges, out_valid=1 and D0..D3 = 00000000.
REQ-033 Accept d42711ae, e0bf98f1, b8b45de5, 1e415230 -> D0..D3 = 193de3be, a0f4e22b, 9ac68d2a, e9f84808 (FIPS-197 App. B round 1).
REQ-034 Byte check: input word 7c16ed63 -> output word 01ff5300.
REQ-035 Hold out_ready=0 for 10 cycles in DONE, driving new in_valid and data -> outputs stay stable and in_ready=0; then out_ready=1 with in_valid=1 -> the new state is accepted on the same edge.
REQ-036 Drop rst_n in the second BUSY cycle -> out_valid=0 and D*=0 immediately; after release, in_ready=1 and the next operation is correct.
REQ-037 Run REQ-032 and REQ-033 with INV_SUB_BYTE_FAST_EN defined -> identical results with out_valid one edge after acceptance.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: word/byte widths, InvSubBytes FSM encoding and the FIPS-197 inverse S-box.
package aes_pkg;

    localparam int WORD_W    = 32;
    localparam int BYTE_W    = 8;
    localparam int NUM_WORDS = 4;

    typedef logic [WORD_W-1:0] word_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [BYTE_W-1:0] inv_sbox_f(input logic [BYTE_W-1:0] b);
        return INV_SBOX[b];
    endfunction

endpackage

// File: rtl/inv_sub_byte_iter_inv_sub_word.sv
// InvSubWord: stateless 32-bit inverse S-box substitution, one lookup per byte.
module InvSubWord
    import aes_pkg::*;
(
    input  logic [31:0] in_word,
    output logic [31:0] out_word
);

    // Bytes are independent, so each lane is a plain table lookup.
    always_comb begin
        out_word = 32'h0;
        for (int i = 0; i < 4; i++) begin
            out_word[i*BYTE_W +: BYTE_W] = inv_sbox_f(in_word[i*BYTE_W +: BYTE_W]);
        end
    end

endmodule

// File: rtl/inv_sub_byte_iter.sv
// Iterative AES InvSubBytes over a 4-column state with valid/ready handshakes on both sides.
// Build option INV_SUB_BYTE_FAST_EN: four InvSubWord lanes finish BUSY in one cycle instead of four.
module inv_sub_byte_iter
    import aes_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] S0_in,
    input  logic [31:0] S1_in,
    input  logic [31:0] S2_in,
    input  logic [31:0] S3_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] D0_out,
    output logic [31:0] D1_out,
    output logic [31:0] D2_out,
    output logic [31:0] D3_out
);

    logic [1:0]                  state_q, state_d;
    logic [1:0]                  cnt_q, cnt_d;
    logic [NUM_WORDS-1:0][WORD_W-1:0] word_q, word_d;
    logic [NUM_WORDS-1:0][WORD_W-1:0] res_q, res_d;
    logic                        accept_s;

`ifdef INV_SUB_BYTE_FAST_EN
    logic [NUM_WORDS-1:0][WORD_W-1:0] sub_all_s;

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_lane
        InvSubWord u_inv_sub_word (
            .in_word  (word_q[g]),
            .out_word (sub_all_s[g])
        );
    end
`else
    word_t sel_word_s;
    word_t sel_sub_s;

    assign sel_word_s = word_q[cnt_q];

    InvSubWord u_inv_sub_word (
        .in_word  (sel_word_s),
        .out_word (sel_sub_s)
    );
`endif

    // DONE may hand straight over to a new state when the sink drains the result.
    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign D0_out    = res_q[0];
    assign D1_out    = res_q[1];
    assign D2_out    = res_q[2];
    assign D3_out    = res_q[3];

    // Next-state, counter, input capture and result write.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        res_d   = res_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    word_d  = {S3_in, S2_in, S1_in, S0_in};
                    cnt_d   = 2'd0;
                    state_d = ST_BUSY;
                end else if (state_q == ST_DONE && out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = state_q;
                end
            end
            ST_BUSY: begin
`ifdef INV_SUB_BYTE_FAST_EN
                res_d   = sub_all_s;
                cnt_d   = 2'd0;
                state_d = ST_DONE;
`else
                res_d[cnt_q] = sel_sub_s;
                cnt_d        = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 2'd0;
            end
        endcase
    end

    // State registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 2'd0;
            word_q  <= 128'h0;
            res_q   <= 128'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_inv_sub_byte_iter.sv
// Randomized self-checking bench for inv_sub_byte_iter; reference S-box derived from GF(2^8) arithmetic.
module tb_inv_sub_byte_iter;

`ifdef INV_SUB_BYTE_FAST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 4;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] S0_in, S1_in, S2_in, S3_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] D0_out, D1_out, D2_out, D3_out;
    logic [127:0] d_s;

    int checks   = 0;
    int failures = 0;
    logic [7:0] inv_tbl [256];

    inv_sub_byte_iter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .S0_in     (S0_in),
        .S1_in     (S1_in),
        .S2_in     (S2_in),
        .S3_in     (S3_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D0_out    (D0_out),
        .D1_out    (D1_out),
        .D2_out    (D2_out),
        .D3_out    (D3_out)
    );

    assign d_s = {D0_out, D1_out, D2_out, D3_out};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (gf_mul(a, 8'(b)) == 8'h01) r = 8'(b);
        end
        return r;
    endfunction

    // Forward S-box from the field inverse plus affine map, then inverted into a lookup.
    task automatic build_ref();
        logic [7:0] b, s;
        for (int x = 0; x < 256; x++) begin
            b = gf_inv(8'(x));
            s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            inv_tbl[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model_inv(input logic [127:0] st);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = inv_tbl[st[i*8 +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_state(input logic [127:0] st);
        S0_in = st[127:96];
        S1_in = st[95:64];
        S2_in = st[63:32];
        S3_in = st[31:0];
    endtask

    // Called #1 after the accepting edge; counts edges until out_valid, with junk on the inputs.
    task automatic wait_done(output int lat);
        lat = 0;
        in_valid = 1'b0;
        drive_state(rand128());
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            in_valid = 1'($urandom_range(0, 1));
            drive_state(rand128());
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        check_eq({tag, "_in_ready_stall"}, 128'(in_ready), 128'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq({tag, "_idle_valid"}, 128'(out_valid), 128'd0);
    endtask

    task automatic run_op(input string tag, input logic [127:0] st, input logic [127:0] exp);
        int lat;
        @(negedge clk);
        drive_state(st);
        in_valid  = 1'b1;
        out_ready = 1'b0;
        check_eq({tag, "_in_ready"}, 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        wait_done(lat);
        check_eq({tag, "_latency"}, 128'(lat), 128'(LAT));
        check_eq({tag, "_data"}, d_s, exp);
        drain(tag);
    endtask

    initial begin
        logic [127:0] st_a, st_b, exp_a, sweep;
        int lat;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        drive_state(128'h0);
        build_ref();
        #1;
        check_eq("reset_out_valid", 128'(out_valid), 128'd0);
        check_eq("reset_data", d_s, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("reset_in_ready", 128'(in_ready), 128'd1);

        run_op("all63", {4{32'h63636363}}, 128'h0);
        run_op("fips_b", {32'hd42711ae, 32'he0bf98f1, 32'hb8b45de5, 32'h1e415230},
               {32'h193de3be, 32'ha0f4e22b, 32'h9ac68d2a, 32'he9f84808});
        st_a = rand128();
        st_a[127:96] = 32'h7c16ed63;
        exp_a = model_inv(st_a);
        check_eq("byte_model", 128'(exp_a[127:96]), 128'h01ff5300);
        run_op("byte_word", st_a, {32'h01ff5300, exp_a[95:0]});

        // Every byte value once across the sweep.
        for (int k = 0; k < 16; k++) begin
            for (int j = 0; j < 16; j++) sweep[j*8 +: 8] = 8'(k*16 + j);
            run_op($sformatf("sweep%0d", k), sweep, model_inv(sweep));
        end
        for (int k = 0; k < 12; k++) begin
            st_a = rand128();
            run_op($sformatf("rand%0d", k), st_a, model_inv(st_a));
        end

        // Stall in DONE with a new request pending, then same-edge handover.
        st_a = rand128();
        st_b = rand128();
        exp_a = model_inv(st_a);
        @(negedge clk);
        drive_state(st_a);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat);
        check_eq("stall_latency", 128'(lat), 128'(LAT));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            drive_state(rand128());
            #1;
            check_eq($sformatf("stall_data%0d", c), d_s, exp_a);
            check_eq($sformatf("stall_ready%0d", c), 128'({out_valid, in_ready}), 128'b10);
        end
        @(negedge clk);
        drive_state(st_b);
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        check_eq("handover_in_ready", 128'(in_ready), 128'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_eq("handover_busy", 128'(out_valid), 128'd0);
        wait_done(lat);
        check_eq("handover_latency", 128'(lat), 128'(LAT));
        check_eq("handover_data", d_s, model_inv(st_b));
        drain("handover");

        // Reset during the second BUSY cycle.
        @(negedge clk);
        drive_state(rand128());
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_valid", 128'(out_valid), 128'd0);
        check_eq("midrst_data", d_s, 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("postrst_state", 128'({out_valid, in_ready}), 128'b01);
        check_eq("postrst_data", d_s, 128'h0);
        st_a = rand128();
        run_op("postrst_op", st_a, model_inv(st_a));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
